alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue controller sitting on the initiator side of the datapath ALU. It accepts one instruction at a time over a valid/ready handshake and decodes it. It reads two source operands from an internal register file and drives opcode and operands to the external combinational ALU. It then captures the ALU result, writes it back, and reports completion. It is the block that produces what the ALU consumes.

## Interface
Parameters:
- `opsize`, 4, opcode field width; the opcode encodings come from the shared package.
- `aluwidth`, 8, data width of ALU operands, results and registers.
- `regaddr`, 3, register address width; the register file has 2^regaddr entries.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: instruction offered.
- `instr_ready` output 1: block can accept; high only in IDLE.
- `instr` input opsize+3*regaddr: instruction word, packed as {opcode, rd, rs1, rs2}, MSB first.
- `wr_en`, `wr_addr[regaddr]`, `wr_data[aluwidth]` inputs: external register preload port.
- `alu_opcode` output opsize: to ALU `opcode`.
- `alu_in1`, `alu_in2` outputs aluwidth: to ALU `in1` and `in2`.
- `alu_out` input aluwidth: from ALU `out`.
- `done_valid` output 1: one-cycle pulse; writeback committed.
- `done_rd` output regaddr: destination of the completed instruction.
- `done_data` output aluwidth: value written.
- `illegal` output 1: one-cycle pulse; opcode not in {ADD, SUB, AND, OR, LS, RS}.
- `busy` output 1: state is not IDLE.

## Operation
- States are IDLE, READ, EXEC and WB.
- **IDLE.** A handshake occurs when `instr_valid` and `instr_ready` are both high.
  - On handshake, latch opcode, rd, rs1 and rs2, then go to READ.
- **READ.** Latch regfile[rs1] into `op1` and regfile[rs2] into `op2`, then go to EXEC.
- **EXEC.** Drive `alu_opcode`, `alu_in1` = `op1` and `alu_in2` = `op2`. Register `alu_out` into `result`, then go to WB.
- **WB, legal opcode.** Write `result` to regfile[rd]. Assert `done_valid`, `done_rd` and `done_data` for this cycle, then go to IDLE.
- **WB, illegal opcode.** No register write and no `done_valid`. Pulse `illegal` instead. The ALU returns 0 for such codes, but the block must not rely on that.
- **Arithmetic.** ADD and SUB wrap modulo 2^aluwidth. For LS and RS, `in2` is the full-width shift amount, and any amount ≥ aluwidth yields 0. The ALU implements these; the bench checks them end to end.
- **Hazards.**
  - rd equal to rs1 or rs2 is safe, because operands are read in READ, before the write.
  - Back-to-back instructions see prior results, because writeback completes before the next READ.
- **Preload port.** `wr_en` writes in any state.
  - If it coincides with a WB write to the same address, WB wins.
  - A preload to rs1 or rs2 in the same cycle as READ is not visible; READ gets the old value.
- **Reset.** Asynchronous and usable mid-instruction. It goes to IDLE, clears every register to 0, and drops any in-flight instruction with no done or illegal pulse.

## Timing
- **Reset values.**
  - `instr_ready` = 1.
  - `busy`, `done_valid` and `illegal` = 0.
  - `alu_opcode`, `alu_in1`, `alu_in2`, `done_rd` and `done_data` = 0.
- **Latency.** With the handshake at edge N, `done_valid` (or `illegal`) is high in the cycle after edge N+3. The earliest next handshake is at edge N+4.
- **Throughput.** One instruction per 4 cycles; `instr_ready` is low for 3 cycles after each accept.
- **ALU outputs.** `alu_*` outputs are registered and change only on entering EXEC. They hold their values outside EXEC.
- **Handshake.** `instr` is sampled only at the handshake edge. `instr_valid` while not ready is ignored; the source holds.

## Configuration
- **`ALU_REG_ZERO_EN` defined.**
  - Register 0 reads as 0 at all times, and writes to it (WB or preload) are discarded.
  - `done_valid` still pulses for rd = 0, with `done_data` showing the discarded result.
- **`ALU_REG_ZERO_EN` undefined.** Register 0 is an ordinary register.

## Structure
- **Shared package.**
  - Opcode constants ADD=0, SUB=1, AND=2, OR=3, LS=4, RS=5.
  - Default `opsize` and `aluwidth`.
  - The state encoding: IDLE=0, READ=1, EXEC=2, WB=3.
  - The instruction field offsets.
  - The ALU and this controller share these definitions.
- **Sub-module `alu_regfile`.** 2^regaddr × aluwidth registers with two asynchronous read ports, a WB write port and a lower-priority preload write port. It applies the `ALU_REG_ZERO_EN` gating and the asynchronous clear.

## Test plan
- **ADD.** Preload r1=0x05 and r2=0x03, issue ADD r3,r1,r2 → `alu_in1`=0x05 and `alu_in2`=0x03 in EXEC; `done_valid` 4 cycles after accept with `done_rd`=3 and `done_data`=0x08; r3 reads 0x08.
- **SUB wrap and aliasing.** r1=0x02, r2=0x05, SUB r1,r1,r2 → `done_data`=0xFD and r1=0xFD; next ADD r4,r1,r1 → 0xFA.
- **Shift bounds.** r1=0x81, r2=0x01: LS → 0x02; RS → 0x40; with r2=0x08, LS → 0x00.
- **Illegal opcode.** Opcode 7 with rd=5 → `illegal` pulses once, `done_valid` stays 0, and r5 is unchanged.
- **Handshake and collision.**
  - Hold `instr_valid` continuously with 3 instructions → accepts spaced exactly 4 cycles apart.
  - `wr_en` to rd during WB → the WB value is retained.
- **Reset and zero register.**
  - Assert `rst_n`=0 during EXEC → outputs return to reset values immediately, with no `done_valid`, and all registers read 0.
  - With `ALU_REG_ZERO_EN` defined, ADD r0 with result 0x08 → r0 stays 0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, default widths,
// controller state encoding and instruction field positions.
package alu_issue_ctrl_pkg;

  localparam int unsigned OPSIZE_DEF   = 4;
  localparam int unsigned ALUWIDTH_DEF = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_LS  = 4'd4;
  localparam logic [3:0] OP_RS  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Field index within {opcode, rd, rs1, rs2}; bit offset is index * regaddr.
  localparam int unsigned FLD_RS2 = 0;
  localparam int unsigned FLD_RS1 = 1;
  localparam int unsigned FLD_RD  = 2;
  localparam int unsigned FLD_OP  = 3;

  function automatic logic op_legal(input logic [31:0] op);
    return op <= 32'(OP_RS);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: two async read ports, WB write port over a preload write port.
// Honours ALU_REG_ZERO_EN (register 0 hardwired to zero).
module alu_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned aluwidth = ALUWIDTH_DEF,
  parameter int unsigned regaddr  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [regaddr-1:0]  rd_addr1,
  input  logic [regaddr-1:0]  rd_addr2,
  output logic [aluwidth-1:0] rd_data1,
  output logic [aluwidth-1:0] rd_data2,
  input  logic                wb_en,
  input  logic [regaddr-1:0]  wb_addr,
  input  logic [aluwidth-1:0] wb_data,
  input  logic                pre_en,
  input  logic [regaddr-1:0]  pre_addr,
  input  logic [aluwidth-1:0] pre_data
);

  localparam int unsigned DEPTH = 1 << regaddr;

  logic [aluwidth-1:0] regs [DEPTH];
  logic                wb_ok;
  logic                pre_ok;

`ifdef ALU_REG_ZERO_EN
  assign wb_ok    = wb_en && (wb_addr != '0);
  assign pre_ok   = pre_en && (pre_addr != '0);
  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
`else
  assign wb_ok    = wb_en;
  assign pre_ok   = pre_en;
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
`endif

  // WB write is issued last so it overrides a preload to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (pre_ok) regs[pre_addr] <= pre_data;
      if (wb_ok)  regs[wb_addr]  <= wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accept, read operands, drive external ALU, write back, report.
// Optional ALU_REG_ZERO_EN makes register 0 a constant zero.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned opsize   = OPSIZE_DEF,
  parameter int unsigned aluwidth = ALUWIDTH_DEF,
  parameter int unsigned regaddr  = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [opsize+3*regaddr-1:0] instr,
  input  logic                        wr_en,
  input  logic [regaddr-1:0]          wr_addr,
  input  logic [aluwidth-1:0]         wr_data,
  output logic [opsize-1:0]           alu_opcode,
  output logic [aluwidth-1:0]         alu_in1,
  output logic [aluwidth-1:0]         alu_in2,
  input  logic [aluwidth-1:0]         alu_out,
  output logic                        done_valid,
  output logic [regaddr-1:0]          done_rd,
  output logic [aluwidth-1:0]         done_data,
  output logic                        illegal,
  output logic                        busy
);

  state_t              state, state_next;
  logic [opsize-1:0]   opc_q;
  logic [regaddr-1:0]  rd_q, rs1_q, rs2_q;
  logic [aluwidth-1:0] rd_data1, rd_data2, result;
  logic                legal, wb_en;

  assign legal       = op_legal(32'(opc_q));
  assign wb_en       = (state == ST_WB) && legal;
  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  alu_regfile #(
    .aluwidth (aluwidth),
    .regaddr  (regaddr)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rs1_q),
    .rd_addr2 (rs2_q),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (result),
    .pre_en   (wr_en),
    .pre_addr (wr_addr),
    .pre_data (wr_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (instr_valid) state_next = ST_READ;
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The registered ALU operands double as the op1/op2 latches captured in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      opc_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      alu_opcode <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      result     <= '0;
      done_valid <= 1'b0;
      done_rd    <= '0;
      done_data  <= '0;
      illegal    <= 1'b0;
    end else begin
      state      <= state_next;
      done_valid <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        ST_IDLE: if (instr_valid) begin
          opc_q <= instr[FLD_OP*regaddr +: opsize];
          rd_q  <= instr[FLD_RD*regaddr +: regaddr];
          rs1_q <= instr[FLD_RS1*regaddr +: regaddr];
          rs2_q <= instr[FLD_RS2*regaddr +: regaddr];
        end
        ST_READ: begin
          alu_opcode <= opc_q;
          alu_in1    <= rd_data1;
          alu_in2    <= rd_data2;
        end
        ST_EXEC: result <= alu_out;
        ST_WB: begin
          if (legal) begin
            done_valid <= 1'b1;
            done_rd    <= rd_q;
            done_data  <= result;
          end else begin
            illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and register model.
module tb_alu_issue_ctrl;

  localparam int OPS = 4;
  localparam int W   = 8;
  localparam int RA  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [OPS+3*RA-1:0] instr = '0;
  logic              wr_en = 1'b0;
  logic [RA-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic [OPS-1:0]    alu_opcode;
  logic [W-1:0]      alu_in1, alu_in2, alu_out;
  logic              done_valid;
  logic [RA-1:0]     done_rd;
  logic [W-1:0]      done_data;
  logic              illegal;
  logic              busy;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          prev_acc = -1;
  int          model_regs [8];

  alu_issue_ctrl #(
    .opsize   (OPS),
    .aluwidth (W),
    .regaddr  (RA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alu_opcode  (alu_opcode),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU seen by the controller.
  always_comb begin
    alu_out = '0;
    case (alu_opcode)
      4'd0: alu_out = alu_in1 + alu_in2;
      4'd1: alu_out = alu_in1 - alu_in2;
      4'd2: alu_out = alu_in1 & alu_in2;
      4'd3: alu_out = alu_in1 | alu_in2;
      4'd4: alu_out = (alu_in2 >= 8'd8) ? '0 : alu_in1 << alu_in2;
      4'd5: alu_out = (alu_in2 >= 8'd8) ? '0 : alu_in1 >> alu_in2;
      default: alu_out = '0;
    endcase
  end

  function automatic int rd_model(input int a);
`ifdef ALU_REG_ZERO_EN
    if (a == 0) return 0;
`endif
    return model_regs[a];
  endfunction

  function automatic void wr_model(input int a, input int v);
`ifdef ALU_REG_ZERO_EN
    if (a == 0) return;
`endif
    model_regs[a] = v % 256;
  endfunction

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return (b >= 8) ? 0 : (a * (1 << b)) % 256;
      5: return (b >= 8) ? 0 : a / (1 << b);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done_valid, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_opcode"}, alu_opcode, 0);
    chk({tag, "_in1"}, alu_in1, 0);
    chk({tag, "_in2"}, alu_in2, 0);
    chk({tag, "_done_rd"}, done_rd, 0);
    chk({tag, "_done_data"}, done_data, 0);
  endtask

  task automatic preload(input int a, input int v);
    wr_en = 1'b1; wr_addr = RA'(a); wr_data = W'(v);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wr_model(a, v);
  endtask

  // mode 0: plain; 1: preload rs1 with pval during READ; 2: preload rd with pval during WB.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                       input int mode, input int pval, input bit hold);
    int n, a, b, exp, acc;
    bit lg;
    instr = {4'(op), 3'(rd), 3'(rs1), 3'(rs2)};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin
      chk("handshake_timeout", instr_ready, 1);
      instr_valid = 1'b0;
      return;
    end
    a = rd_model(rs1); b = rd_model(rs2);
    lg = (op <= 5);
    exp = ref_alu(op, a, b);
    @(posedge clk); #1;
    acc = int'(cyc);
    if (hold && prev_acc >= 0) chk("accept_spacing", acc - prev_acc, 4);
    prev_acc = hold ? acc : -1;
    if (!hold) instr_valid = 1'b0;
    chk("ready_low", instr_ready, 0);
    chk("busy_high", busy, 1);
    if (mode == 1) begin wr_en = 1'b1; wr_addr = RA'(rs1); wr_data = W'(pval); end
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (mode == 1) wr_model(rs1, pval);
    chk("exec_opcode", alu_opcode, op);
    chk("exec_in1", alu_in1, a);
    chk("exec_in2", alu_in2, b);
    @(posedge clk); #1;
    chk("wb_no_done", done_valid, 0);
    if (mode == 2) begin
      wr_en = 1'b1; wr_addr = RA'(rd); wr_data = W'(pval);
      wr_model(rd, pval);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (lg) wr_model(rd, exp);
    chk("done_valid", done_valid, lg);
    chk("illegal", illegal, !lg);
    if (lg) begin
      chk("done_rd", done_rd, rd);
      chk("done_data", done_data, exp);
    end
    chk("ready_back", instr_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD and readback of r3
    preload(1, 8'h05); preload(2, 8'h03);
    issue(0, 3, 1, 2, 0, 0, 0);
    issue(3, 6, 3, 3, 0, 0, 0);
    chk("add_readback", done_data, 8'h08);

    // SUB wrap with rd aliasing rs1, then dependent ADD
    preload(1, 8'h02); preload(2, 8'h05);
    issue(1, 1, 1, 2, 0, 0, 0);
    chk("sub_wrap", done_data, 8'hFD);
    issue(0, 4, 1, 1, 0, 0, 0);
    chk("sub_then_add", done_data, 8'hFA);

    // Shift bounds
    preload(1, 8'h81); preload(2, 8'h01);
    issue(4, 3, 1, 2, 0, 0, 0);
    issue(5, 3, 1, 2, 0, 0, 0);
    preload(2, 8'h08);
    issue(4, 3, 1, 2, 0, 0, 0);
    issue(5, 3, 1, 2, 0, 0, 0);
    preload(2, 8'hC8);
    issue(4, 3, 1, 2, 0, 0, 0);

    // Illegal opcode leaves r5 untouched and pulses once
    preload(5, 8'h5A);
    issue(7, 5, 1, 2, 0, 0, 0);
    @(posedge clk); #1;
    chk("illegal_single_pulse", illegal, 0);
    issue(3, 6, 5, 5, 0, 0, 0);
    issue(12, 5, 1, 2, 0, 0, 0);
    issue(3, 6, 5, 5, 0, 0, 0);

    // Continuous instr_valid: accepts four cycles apart
    issue(0, 3, 1, 2, 0, 0, 1);
    issue(1, 4, 3, 2, 0, 0, 1);
    issue(2, 6, 4, 3, 0, 0, 1);
    instr_valid = 1'b0;
    prev_acc = -1;

    // Preload colliding with WB, and preload during READ
    preload(1, 8'h10); preload(2, 8'h20);
    issue(0, 3, 1, 2, 2, 8'hAA, 0);
    issue(3, 6, 3, 3, 0, 0, 0);
    issue(0, 4, 1, 2, 1, 8'h11, 0);
    issue(3, 6, 1, 1, 0, 0, 0);

    // Register 0 behaviour (constant zero when ALU_REG_ZERO_EN)
    preload(1, 8'h05); preload(2, 8'h03);
    issue(0, 0, 1, 2, 0, 0, 0);
    chk("r0_done_data", done_data, 8'h08);
    issue(3, 3, 0, 0, 0, 0, 0);
    preload(0, 8'h77);
    issue(3, 3, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) preload(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), int'($urandom_range(0, 255)), 0);
    end

    // Reset during EXEC drops the instruction and clears everything
    preload(1, 8'h33);
    instr = {4'd0, 3'd2, 3'd1, 3'd1};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_in1", alu_in1, 8'h33);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_no_done", done_valid, 0);
      chk("reset_no_illegal", illegal, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("after_reset_no_done", done_valid, 0);
    end
    for (int r = 0; r < 8; r++) begin
      issue(3, r, r, r, 0, 0, 0);
      chk("cleared_reg", done_data, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
